controle_teclado_modos: RTL and testbench

Keypad front-end and mode controller for the stopwatch/calculator top level. It debounces the raw 5-bit keypad code and turns each press into one key event. It runs the CRON/CALC mode state machine and delivers every non-mode key event to the currently active consumer, stopwatch counter or calculator, over a valid/ready handshake. It sits between the keypad pins and the two datapaths, and replaces ad-hoc per-cycle key sampling.

---
 rtl/teclado_pkg.sv | 31 +++
 rtl/controle_teclado_modos_if.sv | 28 ++
 rtl/debounce_tecla.sv | 85 ++++++++
 rtl/controle_teclado_modos.sv | 68 ++++++
 tb/tb_controle_teclado_modos.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/teclado_pkg.sv
// Shared keypad codes, mode encoding and FSM state types for the
// stopwatch/calculator keypad front-end.
package teclado_pkg;

  typedef logic [4:0] tecla_t;

  localparam tecla_t T_0    = 5'd0;
  localparam tecla_t T_1    = 5'd1;
  localparam tecla_t T_2    = 5'd2;
  localparam tecla_t T_3    = 5'd3;
  localparam tecla_t T_4    = 5'd4;
  localparam tecla_t T_5    = 5'd5;
  localparam tecla_t T_6    = 5'd6;
  localparam tecla_t T_7    = 5'd7;
  localparam tecla_t T_8    = 5'd8;
  localparam tecla_t T_9    = 5'd9;
  localparam tecla_t T_A    = 5'd10;
  localparam tecla_t T_B    = 5'd11;
  localparam tecla_t T_C    = 5'd12;
  localparam tecla_t T_D    = 5'd13;
  localparam tecla_t T_ASTE = 5'd14;
  localparam tecla_t T_HASH = 5'd15;
  localparam tecla_t T_NULL = 5'd31;

  localparam logic MODO_CRON = 1'b0;
  localparam logic MODO_CALC = 1'b1;

  typedef enum logic [1:0] {D_IDLE, D_PRESS, D_HELD, D_REL} deb_state_t;
  typedef enum logic {M_CRON, M_CALC} modo_state_t;

endpackage

// File: rtl/controle_teclado_modos_if.sv
// Key-event handshake from the keypad controller to the stopwatch counter
// and calculator consumers.
interface controle_teclado_modos_if;
  import teclado_pkg::*;

  tecla_t ev_code;
  logic   cron_valid;
  logic   cron_ready;
  logic   calc_valid;
  logic   calc_ready;

  modport master (
    output ev_code,
    output cron_valid,
    output calc_valid,
    input  cron_ready,
    input  calc_ready
  );

  modport slave (
    input  ev_code,
    input  cron_valid,
    input  calc_valid,
    output cron_ready,
    output calc_ready
  );

endinterface

// File: rtl/debounce_tecla.sv
// Registers the raw keypad code and debounces it into a one-cycle press
// strobe; held keys do not auto-repeat.
module debounce_tecla
  import teclado_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 20
) (
  input  logic   clk,
  input  logic   rst_n,
  input  tecla_t key,
  output logic   press,
  output tecla_t press_code
);

  localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE - 1);
  localparam bit         SINGLE   = (DEBOUNCE == 1);

  tecla_t     key_q;
  tecla_t     cand;
  logic [7:0] cnt;
  deb_state_t state;

  // cnt holds how many consecutive cycles the current candidate (or NULL,
  // while releasing) has been seen; the transition fires on the cycle that
  // brings it to DEBOUNCE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q      <= T_NULL;
      cand       <= T_NULL;
      cnt        <= '0;
      state      <= D_IDLE;
      press      <= 1'b0;
      press_code <= T_NULL;
    end else begin
      key_q <= key;
      press <= 1'b0;
      case (state)
        D_IDLE: begin
          if (key_q != T_NULL) begin
            cand <= key_q;
            cnt  <= 8'd1;
            if (SINGLE) begin
              state      <= D_HELD;
              press      <= 1'b1;
              press_code <= key_q;
            end else begin
              state <= D_PRESS;
            end
          end
        end
        D_PRESS: begin
          if (key_q == T_NULL) begin
            state <= D_IDLE;
          end else if (key_q != cand) begin
            cand <= key_q;
            cnt  <= 8'd1;
          end else begin
            cnt <= cnt + 8'd1;
            if (cnt == DEB_LAST) begin
              state      <= D_HELD;
              press      <= 1'b1;
              press_code <= cand;
            end
          end
        end
        D_HELD: begin
          if (key_q == T_NULL) begin
            cnt   <= 8'd1;
            state <= SINGLE ? D_IDLE : D_REL;
          end
        end
        D_REL: begin
          if (key_q != T_NULL) begin
            state <= D_HELD;
          end else begin
            cnt <= cnt + 8'd1;
            if (cnt == DEB_LAST) state <= D_IDLE;
          end
        end
        default: state <= D_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/controle_teclado_modos.sv
// Keypad front-end: debounces presses, runs the CRON/CALC mode FSM and
// forwards non-mode key events to the active consumer via one holding slot.
module controle_teclado_modos
  import teclado_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  tecla_t     key,
  output logic       modo,
  output logic [7:0] drop_cnt,
  controle_teclado_modos_if.master bus
);

  logic        press;
  tecla_t      press_code;
  modo_state_t modo_st;
  logic        accept;
  logic        slot_free;
  logic        is_modo_key;

  debounce_tecla #(.DEBOUNCE(DEBOUNCE)) u_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .key        (key),
    .press      (press),
    .press_code (press_code)
  );

  // The slot counts as free when it is being accepted on this same edge.
  always_comb begin
    accept      = (bus.cron_valid & bus.cron_ready) | (bus.calc_valid & bus.calc_ready);
    slot_free   = !(bus.cron_valid | bus.calc_valid) || accept;
    is_modo_key = (modo_st == M_CRON) ? ((press_code == T_HASH) || (press_code == T_ASTE))
                                      : (press_code == T_D);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      modo_st        <= M_CRON;
      bus.ev_code    <= T_NULL;
      bus.cron_valid <= 1'b0;
      bus.calc_valid <= 1'b0;
      drop_cnt       <= '0;
    end else begin
      if (accept) begin
        bus.cron_valid <= 1'b0;
        bus.calc_valid <= 1'b0;
      end
      // Mode keys are also dropped while an event is pending.
      if (press) begin
        if (!slot_free) begin
          if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end else if (is_modo_key) begin
          modo_st <= (modo_st == M_CRON) ? M_CALC : M_CRON;
        end else begin
          bus.ev_code    <= press_code;
          bus.cron_valid <= (modo_st == M_CRON);
          bus.calc_valid <= (modo_st == M_CALC);
        end
      end
    end
  end

  assign modo = (modo_st == M_CALC) ? MODO_CALC : MODO_CRON;

endmodule

// File: tb/tb_controle_teclado_modos.sv
// Directed bench for controle_teclado_modos with DEBOUNCE = 20.
module tb_controle_teclado_modos;
  import teclado_pkg::*;

  localparam int DEB = 20;

  logic       clk;
  logic       rst_n;
  tecla_t     key;
  logic       modo;
  logic [7:0] drop_cnt;
  int         vectors;
  int         miscompares;
  int         pulses;
  int         first_pulse;

  controle_teclado_modos_if bus ();

  controle_teclado_modos #(.DEBOUNCE(DEB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key      (key),
    .modo     (modo),
    .drop_cnt (drop_cnt),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task applyStimulus(input tecla_t k, input logic cr, input logic car);
    key            = k;
    bus.cron_ready = cr;
    bus.calc_ready = car;
  endtask

  task checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives a key and waits until one cycle before its event should appear.
  task pressKey(input tecla_t k);
    key = k;
    repeat (DEB + 1) @(negedge clk);
  endtask

  task releaseKey();
    key = T_NULL;
    repeat (DEB + 5) @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    applyStimulus(T_NULL, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("rst_modo", {7'd0, modo}, 8'd0);
    checkOutput("rst_ev_code", {3'd0, bus.ev_code}, {3'd0, T_NULL});
    checkOutput("rst_cron_valid", {7'd0, bus.cron_valid}, 8'd0);
    checkOutput("rst_calc_valid", {7'd0, bus.calc_valid}, 8'd0);
    checkOutput("rst_drop_cnt", drop_cnt, 8'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] single press, key 5, cron_ready high");
    applyStimulus(5'd5, 1'b1, 1'b0);
    pressKey(5'd5);
    checkOutput("k5_before", {7'd0, bus.cron_valid}, 8'd0);
    @(negedge clk);
    checkOutput("k5_valid", {7'd0, bus.cron_valid}, 8'd1);
    checkOutput("k5_code", {3'd0, bus.ev_code}, 8'd5);
    checkOutput("k5_calc_valid", {7'd0, bus.calc_valid}, 8'd0);
    @(negedge clk);
    checkOutput("k5_accepted", {7'd0, bus.cron_valid}, 8'd0);
    repeat (10) @(negedge clk);
    checkOutput("k5_no_repeat", {7'd0, bus.cron_valid}, 8'd0);
    releaseKey();

    $display("[TB] bouncing key 7");
    pulses      = 0;
    first_pulse = -1;
    for (int i = 0; i < 60; i++) begin
      key = (i < 15 && ((i / 3) % 2 == 1)) ? T_NULL : 5'd7;
      @(negedge clk);
      if (bus.cron_valid) begin
        pulses++;
        if (first_pulse < 0) first_pulse = i;
      end
    end
    checkOutput("bounce_count", 8'(pulses), 8'd1);
    checkOutput("bounce_time", 8'(first_pulse), 8'(12 + DEB + 1));
    releaseKey();

    $display("[TB] mode keys");
    pressKey(T_HASH);
    checkOutput("hash_before", {7'd0, modo}, 8'd0);
    @(negedge clk);
    checkOutput("hash_modo", {7'd0, modo}, 8'd1);
    checkOutput("hash_no_valid", {6'd0, bus.cron_valid, bus.calc_valid}, 8'd0);
    releaseKey();
    pressKey(T_D);
    @(negedge clk);
    checkOutput("d_modo", {7'd0, modo}, 8'd0);
    checkOutput("d_no_valid", {6'd0, bus.cron_valid, bus.calc_valid}, 8'd0);
    releaseKey();
    pressKey(T_ASTE);
    @(negedge clk);
    checkOutput("aste_modo", {7'd0, modo}, 8'd1);
    releaseKey();

    $display("[TB] CALC with calc_ready low, second press dropped");
    applyStimulus(T_NULL, 1'b0, 1'b0);
    pressKey(5'd3);
    @(negedge clk);
    checkOutput("c3_valid", {7'd0, bus.calc_valid}, 8'd1);
    checkOutput("c3_cron_valid", {7'd0, bus.cron_valid}, 8'd0);
    checkOutput("c3_code", {3'd0, bus.ev_code}, 8'd3);
    releaseKey();
    pressKey(5'd4);
    @(negedge clk);
    checkOutput("c4_code_held", {3'd0, bus.ev_code}, 8'd3);
    checkOutput("c4_valid_held", {7'd0, bus.calc_valid}, 8'd1);
    checkOutput("c4_drop_cnt", drop_cnt, 8'd1);
    bus.calc_ready = 1'b1;
    @(negedge clk);
    checkOutput("c3_accepted", {7'd0, bus.calc_valid}, 8'd0);
    bus.calc_ready = 1'b0;
    releaseKey();
    pressKey(T_D);
    @(negedge clk);
    checkOutput("back_to_cron", {7'd0, modo}, 8'd0);
    releaseKey();

    $display("[TB] mode key while CRON event pending");
    pressKey(5'd9);
    @(negedge clk);
    checkOutput("k9_valid", {7'd0, bus.cron_valid}, 8'd1);
    checkOutput("k9_code", {3'd0, bus.ev_code}, 8'd9);
    releaseKey();
    pressKey(T_HASH);
    @(negedge clk);
    checkOutput("hash_dropped_modo", {7'd0, modo}, 8'd0);
    checkOutput("hash_dropped_cnt", drop_cnt, 8'd2);
    checkOutput("k9_still_pending", {3'd0, bus.ev_code}, 8'd9);
    releaseKey();

    $display("[TB] reset with pending event and held key");
    key   = 5'd6;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_cron_valid", {7'd0, bus.cron_valid}, 8'd0);
    checkOutput("midrst_modo", {7'd0, modo}, 8'd0);
    checkOutput("midrst_drop_cnt", drop_cnt, 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (DEB + 1) @(negedge clk);
    checkOutput("held_before", {7'd0, bus.cron_valid}, 8'd0);
    @(negedge clk);
    checkOutput("held_valid", {7'd0, bus.cron_valid}, 8'd1);
    checkOutput("held_code", {3'd0, bus.ev_code}, 8'd6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
